alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Command-side controller that sits directly upstream of the ALU execution units (arithmetic, logic, compare, shift) and consumes their registered results.
- Accepts one operation at a time through a valid/ready handshake and registers the operands.
- Decodes the 4-bit function into a one-hot unit enable plus a 2-bit sub-function, then waits for the selected unit's flag.
- Presents the result on a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand/result width.
- WAIT_MAX, 4, number of WAIT cycles without the selected unit's flag before an error completion is issued (minimum 1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- IN_Valid  input  1  command valid.
- IN_Ready  output  1  command accepted when IN_Valid & IN_Ready at a rising edge.
- IN_A  input  WIDTH  operand A.
- IN_B  input  WIDTH  operand B.
- IN_FUN  input  4  function: [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] sub-function.
- A  output  WIDTH  registered operand to units.
- B  output  WIDTH  registered operand to units.
- ALU_FUN  output  2  registered IN_FUN[1:0].
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  output  1 each  unit enables; one-hot or all zero.
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  WIDTH each  unit results.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  unit result-valid flags.
- OUT_Valid  output  1  result valid.
- OUT_Ready  input  1  result consumed when OUT_Valid & OUT_Ready at a rising edge.
- OUT_Data  output  WIDTH  captured result.
- OUT_Unit  output  2  unit that produced OUT_Data.
- OUT_Err  output  1  set when the completion was caused by timeout.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; A, B, ALU_FUN, all enables, OUT_Valid, OUT_Data, OUT_Unit, OUT_Err and the wait counter go to 0. A reset mid-operation abandons the command; no completion is produced.
- States:
  - IDLE: IN_Ready=1. On accept: register A/B/ALU_FUN/unit select, set the selected enable, go to ISSUE.
  - ISSUE: exactly one cycle with the enable high. Next edge: all enables to 0, clear the counter, go to WAIT.
  - WAIT: sample the selected unit's flag only; flags of other units are ignored.
    - Flag=1: capture the selected OUT into OUT_Data, set OUT_Unit, OUT_Err=0, OUT_Valid=1, go to HOLD.
    - Flag=0: increment the counter. When the counter reaches WAIT_MAX-1 with flag still 0: OUT_Data=0, OUT_Err=1, OUT_Valid=1, go to HOLD.
  - HOLD: OUT_Valid=1; OUT_Data, OUT_Unit and OUT_Err are stable.
    - OUT_Ready=0: stay in HOLD.
    - OUT_Ready=1, IN_Valid=0: clear OUT_Valid, go to IDLE.
    - OUT_Ready=1, IN_Valid=1: clear OUT_Valid and accept the new command on the same edge, go to ISSUE.
- IN_Ready = (IDLE) | (HOLD & OUT_Ready); this is the only combinational path.
- Latency: accept edge E0 → enable high during cycle E0–E1 → unit result visible after E1 → OUT_Valid high after E2. Peak throughput is one command per 3 cycles.
- A, B and ALU_FUN stay stable from accept until the next accept, covering the full ISSUE and WAIT window.
- IN_A, IN_B and IN_FUN are ignored whenever IN_Ready=0.
- No arithmetic is performed here; the counter is $clog2(WAIT_MAX+1) bits and saturates, never wraps.

Decomposition:
- Shared package alu_pkg holds:
  - unit-select constants UNIT_ARITH=0, UNIT_LOGIC=1, UNIT_CMP=2, UNIT_SHIFT=3;
  - state encoding IDLE/ISSUE/WAIT/HOLD;
  - the 4-bit function field positions.
- One sub-module, alu_fun_decoder: combinational IN_FUN[3:2] → one-hot 4-bit enable vector and result/flag mux select.

Test Plan:
- CMP, A=5, B=3, IN_FUN=4'b1010, real CMP unit attached → CMP_Enable high for exactly 1 cycle; OUT_Valid 2 cycles after accept with OUT_Data=2, OUT_Unit=2, OUT_Err=0.
- Hold OUT_Ready=0 for 5 cycles after completion → OUT_Valid, OUT_Data, OUT_Unit stable; IN_Ready=0; a second IN_Valid is not accepted until OUT_Ready=1.
- Back-to-back: in HOLD with OUT_Ready=1 and IN_Valid=1 (CMP, A=7, B=7, FUN=4'b1001) → both handshakes complete on one edge; next result OUT_Data=1.
- Stub unit with flag tied 0, WAIT_MAX=4 → after 4 WAIT cycles OUT_Valid=1, OUT_Err=1, OUT_Data=0; enables were 0 throughout WAIT.
- Assert RST during WAIT → all outputs 0 immediately (asynchronous); after release IN_Ready=1 and no stale OUT_Valid appears.
- Sweep IN_FUN[3:2]=00..11 → exactly the matching enable pulses; ALU_FUN equals IN_FUN[1:0]; the result mux selects the correct unit.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: unit codes, FSM states
// and the layout of the 4-bit function field.
package alu_pkg;

  localparam int NUM_UNITS = 4;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  localparam int FUN_W        = 4;
  localparam int FUN_UNIT_MSB = 3;
  localparam int FUN_UNIT_LSB = 2;
  localparam int FUN_SUB_MSB  = 1;
  localparam int FUN_SUB_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_fun_decoder.sv
// Turns the unit-select field into a one-hot enable vector and the
// result/flag mux select.
module alu_fun_decoder
  import alu_pkg::*;
(
  input  logic [1:0]           unit_field,
  output logic [NUM_UNITS-1:0] unit_onehot,
  output logic [1:0]           unit_sel
);

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_en
      assign unit_onehot[gi] = (unit_field == 2'(gi));
    end
  endgenerate

  assign unit_sel = unit_field;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to the ALU units, waits for the selected
// unit's flag (or times out) and holds the result on a valid/ready output.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int WAIT_MAX = 4
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_Valid,
  output logic             IN_Ready,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [FUN_W-1:0] IN_FUN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             Shift_Enable,
  input  logic [WIDTH-1:0] Arith_OUT,
  input  logic [WIDTH-1:0] Logic_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] Shift_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag,
  output logic             OUT_Valid,
  input  logic             OUT_Ready,
  output logic [WIDTH-1:0] OUT_Data,
  output logic [1:0]       OUT_Unit,
  output logic             OUT_Err
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t                 state_reg;
  logic [1:0]             unit_reg;
  logic [CW-1:0]          cnt_reg;
  logic [NUM_UNITS-1:0]   en_reg;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [1:0]             fun_reg;
  logic [WIDTH-1:0]       data_reg;
  logic [1:0]             out_unit_reg;
  logic                   valid_reg;
  logic                   err_reg;

  logic [NUM_UNITS-1:0]   dec_onehot;
  logic [1:0]             dec_sel;
  logic [WIDTH-1:0]       unit_out [NUM_UNITS];
  logic [NUM_UNITS-1:0]   unit_flag;
  logic                   sel_flag;
  logic [WIDTH-1:0]       sel_data;
  logic                   accept;

  alu_fun_decoder u_dec (
    .unit_field  (IN_FUN[FUN_UNIT_MSB:FUN_UNIT_LSB]),
    .unit_onehot (dec_onehot),
    .unit_sel    (dec_sel)
  );

  assign unit_out[UNIT_ARITH]  = Arith_OUT;
  assign unit_out[UNIT_LOGIC]  = Logic_OUT;
  assign unit_out[UNIT_CMP]    = CMP_OUT;
  assign unit_out[UNIT_SHIFT]  = Shift_OUT;
  assign unit_flag[UNIT_ARITH] = Arith_Flag;
  assign unit_flag[UNIT_LOGIC] = Logic_Flag;
  assign unit_flag[UNIT_CMP]   = CMP_Flag;
  assign unit_flag[UNIT_SHIFT] = Shift_Flag;

  // Only the unit latched at accept is listened to; stray flags are ignored.
  assign sel_flag = unit_flag[unit_reg];
  assign sel_data = unit_out[unit_reg];

  assign IN_Ready = (state_reg == IDLE) | ((state_reg == HOLD) & OUT_Ready);
  assign accept   = IN_Valid & IN_Ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      unit_reg     <= '0;
      cnt_reg      <= '0;
      en_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      fun_reg      <= '0;
      data_reg     <= '0;
      out_unit_reg <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        ISSUE: begin
          en_reg    <= '0;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (sel_flag) begin
            data_reg     <= sel_data;
            out_unit_reg <= unit_reg;
            err_reg      <= 1'b0;
            valid_reg    <= 1'b1;
            state_reg    <= HOLD;
          end else if (cnt_reg == CW'(WAIT_MAX - 1)) begin
            data_reg     <= '0;
            out_unit_reg <= unit_reg;
            err_reg      <= 1'b1;
            valid_reg    <= 1'b1;
            state_reg    <= HOLD;
          end else if (cnt_reg < CW'(WAIT_MAX)) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        HOLD: begin
          if (OUT_Ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Accept from IDLE or HOLD; placed last so it overrides the HOLD->IDLE move.
      if (accept) begin
        a_reg     <= IN_A;
        b_reg     <= IN_B;
        fun_reg   <= IN_FUN[FUN_SUB_MSB:FUN_SUB_LSB];
        unit_reg  <= dec_sel;
        en_reg    <= dec_onehot;
        state_reg <= ISSUE;
      end
    end
  end

  assign A            = a_reg;
  assign B            = b_reg;
  assign ALU_FUN      = fun_reg;
  assign Arith_Enable = en_reg[UNIT_ARITH];
  assign Logic_Enable = en_reg[UNIT_LOGIC];
  assign CMP_Enable   = en_reg[UNIT_CMP];
  assign Shift_Enable = en_reg[UNIT_SHIFT];
  assign OUT_Valid    = valid_reg;
  assign OUT_Data     = data_reg;
  assign OUT_Unit     = out_unit_reg;
  assign OUT_Err      = err_reg;

endmodule
